// File: rtl/rom_access_arbiter.sv
// rom_access_arbiter: shares one combinational instruction ROM between the
// instruction-fetch (if_*) and data-load (ld_*) requesters. It drives the ROM
// for WAIT_CYCLES cycles, captures the 64-bit word, and returns it to the
// winning requester with a one-cycle valid pulse.
// Optional feature: define ROM_ARB_RR_EN for round-robin arbitration on
// contention. Without it, ld_req always has priority over if_req.
module rom_access_arbiter #(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DATA_W      = 64,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_valid,
  output logic [DATA_W-1:0] if_data,
  input  logic              ld_req,
  input  logic [ADDR_W-1:0] ld_addr,
  output logic              ld_gnt,
  output logic              ld_valid,
  output logic [DATA_W-1:0] ld_data,
  output logic [ADDR_W-1:0] rom_address,
  output logic              rom_cs,
  output logic              rom_oe,
  input  logic [DATA_W-1:0] rom_data,
  output logic              busy
);

  localparam int unsigned CNT_W = (WAIT_CYCLES < 1) ? 1 : $clog2(WAIT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_DONE   = 2'd2
  } state_e;

  state_e            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              owner_ld_q;
  logic              pick_ld_d;
  logic [ADDR_W-1:0] grant_addr_d;
  logic [ADDR_W-1:0] aligned_addr_d;
  logic              unused_addr_lsbs;

`ifdef ROM_ARB_RR_EN
  logic last_ld_q;

  // Round-robin: on contention, the requester that was not served last wins.
  always_comb begin
    pick_ld_d = 1'b0;
    if (ld_req && if_req) begin
      pick_ld_d = ~last_ld_q;
    end else begin
      pick_ld_d = ld_req;
    end
  end
`else
  // Fixed priority: a pending load always beats a fetch.
  always_comb begin
    pick_ld_d = ld_req;
  end
`endif

  // Select the winner's address and force word alignment.
  always_comb begin
    grant_addr_d   = pick_ld_d ? ld_addr : if_addr;
    aligned_addr_d = {grant_addr_d[ADDR_W-1:2], 2'b00};
  end

  assign unused_addr_lsbs = ^grant_addr_d[1:0];

  // Access sequencer IDLE -> ACCESS -> DONE, with all outputs registered.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      owner_ld_q  <= 1'b0;
      if_gnt      <= 1'b0;
      ld_gnt      <= 1'b0;
      if_valid    <= 1'b0;
      ld_valid    <= 1'b0;
      if_data     <= '0;
      ld_data     <= '0;
      rom_address <= '0;
      rom_cs      <= 1'b0;
      rom_oe      <= 1'b0;
      busy        <= 1'b0;
`ifdef ROM_ARB_RR_EN
      last_ld_q   <= 1'b0;
`endif
    end else begin
      if_gnt   <= 1'b0;
      ld_gnt   <= 1'b0;
      if_valid <= 1'b0;
      ld_valid <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (if_req || ld_req) begin
            owner_ld_q  <= pick_ld_d;
            rom_address <= aligned_addr_d;
            rom_cs      <= 1'b1;
            rom_oe      <= 1'b1;
            busy        <= 1'b1;
            cnt_q       <= CNT_LOAD;
            if_gnt      <= ~pick_ld_d;
            ld_gnt      <= pick_ld_d;
            state_q     <= S_ACCESS;
`ifdef ROM_ARB_RR_EN
            last_ld_q   <= pick_ld_d;
`endif
          end
        end
        S_ACCESS: begin
          if (cnt_q == '0) begin
            if (owner_ld_q) begin
              ld_data <= rom_data;
            end else begin
              if_data <= rom_data;
            end
            rom_cs   <= 1'b0;
            rom_oe   <= 1'b0;
            if_valid <= ~owner_ld_q;
            ld_valid <= owner_ld_q;
            state_q  <= S_DONE;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        S_DONE: begin
          busy    <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rom_access_arbiter.sv
// Testbench for rom_access_arbiter. u1 (WAIT_CYCLES=1) is checked every cycle
// against a transaction-level model. u3 (WAIT_CYCLES=3) is checked against a
// fixed per-cycle timing table.
module tb_rom_access_arbiter;

  localparam int W1 = 1;
  localparam int W3 = 3;

  logic        clk = 1'b0;
  logic        reset_n;

  logic        if_req, ld_req, if_gnt, ld_gnt, if_valid, ld_valid, rom_cs, rom_oe, busy;
  logic [31:0] if_addr, ld_addr, rom_address;
  logic [63:0] if_data, ld_data, rom_data;

  logic        if_req3, ld_req3, if_gnt3, ld_gnt3, if_valid3, ld_valid3, rom_cs3, rom_oe3, busy3;
  logic [31:0] if_addr3, ld_addr3, rom_address3;
  logic [63:0] if_data3, ld_data3, rom_data3;

  int n_tests = 0;
  int n_fail  = 0;

  // Transaction-level model: k counts the cycles since the grant (0 = idle).
  int          k, own, last;
  logic [31:0] m_addr;
  logic [63:0] m_if, m_ld;
  int          order_q[$];

  always #5 clk = ~clk;

  // ROM contents: words below 0x100 are populated; all other addresses read 0.
  function automatic logic [63:0] rom_word(input logic [31:0] a);
    if (a < 32'h100) return {a ^ 32'hA5A5_0000, ~a};
    return 64'h0;
  endfunction

  assign rom_data  = (rom_cs && rom_oe)   ? rom_word(rom_address)  : 64'hDEAD_BEEF_DEAD_BEEF;
  assign rom_data3 = (rom_cs3 && rom_oe3) ? rom_word(rom_address3) : 64'hDEAD_BEEF_DEAD_BEEF;

  rom_access_arbiter #(.ADDR_W(32), .DATA_W(64), .WAIT_CYCLES(W1)) u1 (
    .clock(clk), .reset_n(reset_n),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_valid(if_valid), .if_data(if_data),
    .ld_req(ld_req), .ld_addr(ld_addr), .ld_gnt(ld_gnt), .ld_valid(ld_valid), .ld_data(ld_data),
    .rom_address(rom_address), .rom_cs(rom_cs), .rom_oe(rom_oe), .rom_data(rom_data), .busy(busy)
  );

  rom_access_arbiter #(.ADDR_W(32), .DATA_W(64), .WAIT_CYCLES(W3)) u3 (
    .clock(clk), .reset_n(reset_n),
    .if_req(if_req3), .if_addr(if_addr3), .if_gnt(if_gnt3), .if_valid(if_valid3), .if_data(if_data3),
    .ld_req(ld_req3), .ld_addr(ld_addr3), .ld_gnt(ld_gnt3), .ld_valid(ld_valid3), .ld_data(ld_data3),
    .rom_address(rom_address3), .rom_cs(rom_cs3), .rom_oe(rom_oe3), .rom_data(rom_data3), .busy(busy3)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    k = 0; own = 0; last = 0; m_addr = '0; m_if = '0; m_ld = '0;
  endtask

  // Apply the requests that the next rising edge will sample.
  task automatic model_advance();
    if (k == 0) begin
      if (if_req || ld_req) begin
`ifdef ROM_ARB_RR_EN
        own  = (if_req && ld_req) ? (1 - last) : (ld_req ? 1 : 0);
        last = own;
`else
        own  = ld_req ? 1 : 0;
`endif
        m_addr = (own == 1 ? ld_addr : if_addr) & ~32'h3;
        k = 1;
      end
    end else begin
      if (k == W1) begin
        if (own == 1) m_ld = rom_word(m_addr);
        else          m_if = rom_word(m_addr);
      end
      k = (k == W1 + 1) ? 0 : k + 1;
    end
  endtask

  task automatic check_u1();
    chk("if_gnt",   64'(if_gnt),   64'(k == 1 && own == 0));
    chk("ld_gnt",   64'(ld_gnt),   64'(k == 1 && own == 1));
    chk("if_valid", 64'(if_valid), 64'(k == W1 + 1 && own == 0));
    chk("ld_valid", 64'(ld_valid), 64'(k == W1 + 1 && own == 1));
    chk("rom_cs",   64'(rom_cs),   64'(k >= 1 && k <= W1));
    chk("rom_oe",   64'(rom_oe),   64'(k >= 1 && k <= W1));
    chk("busy",     64'(busy),     64'(k != 0));
    chk("if_data",  if_data, m_if);
    chk("ld_data",  ld_data, m_ld);
    if (k >= 1 && k <= W1) chk("rom_address", 64'(rom_address), 64'(m_addr));
    if (ld_gnt) order_q.push_back(1);
    if (if_gnt) order_q.push_back(0);
  endtask

  // A requester drops its req once the model says it has been granted.
  task automatic auto_drop();
    if (k == 1) begin
      if (own == 0) if_req = 1'b0;
      else          ld_req = 1'b0;
    end
  endtask

  task automatic tick();
    model_advance();
    @(negedge clk);
    check_u1();
    auto_drop();
  endtask

  initial begin
    logic [31:0] a;
    reset_n = 1'b0;
    if_req = 0; ld_req = 0; if_addr = '0; ld_addr = '0;
    if_req3 = 0; ld_req3 = 0; if_addr3 = '0; ld_addr3 = '0;
    model_reset();
    @(negedge clk);
    check_u1();
    chk("rst_addr", 64'(rom_address), 64'h0);
    reset_n = 1'b1;
    repeat (2) tick();

    // Single fetch at 0x4.
    if_addr = 32'h4; if_req = 1'b1;
    tick();
    chk("t2_gnt", 64'(if_gnt), 64'h1);
    chk("t2_addr", 64'(rom_address), 64'h4);
    tick();
    chk("t2_valid", 64'(if_valid), 64'h1);
    chk("t2_data", if_data, rom_word(32'h4));
    tick();

    // Unaligned load at 0xB is served from word 0x8.
    ld_addr = 32'h0000_000B; ld_req = 1'b1;
    tick();
    chk("t3_addr", 64'(rom_address), 64'h8);
    tick();
    chk("t3_data", ld_data, rom_word(32'h8));
    tick();

    // Unmapped fetch returns zero and leaves the load data alone.
    if_addr = 32'h100; if_req = 1'b1;
    tick();
    tick();
    chk("t6_if_data", if_data, 64'h0);
    chk("t6_ld_data", ld_data, rom_word(32'h8));
    tick();

    // Randomized traffic on both requesters.
    for (int i = 0; i < 300; i++) begin
      if (!if_req) begin
        if_addr = 32'($urandom_range(0, 32'h13F));
        if ($urandom_range(0, 2) == 0) if_req = 1'b1;
      end
      if (!ld_req) begin
        ld_addr = 32'($urandom_range(0, 32'h13F));
        if ($urandom_range(0, 2) == 0) ld_req = 1'b1;
      end
      tick();
    end
    if_req = 0; ld_req = 0;
    repeat (3) tick();

    // Asynchronous reset in the middle of an access.
    a = 32'($urandom_range(0, 32'hFF));
    if_addr = a; if_req = 1'b1;
    tick();
    #2 reset_n = 1'b0;
    #1;
    chk("t1_cs", 64'(rom_cs), 64'h0);
    chk("t1_oe", 64'(rom_oe), 64'h0);
    chk("t1_busy", 64'(busy), 64'h0);
    chk("t1_if_valid", 64'(if_valid), 64'h0);
    chk("t1_ld_valid", 64'(ld_valid), 64'h0);
    chk("t1_if_data", if_data, 64'h0);
    chk("t1_ld_data", ld_data, 64'h0);
    if_req = 0; ld_req = 0;
    model_reset();
    @(negedge clk);
    check_u1();
    reset_n = 1'b1;
    repeat (3) tick();

    // Contention: both requests are re-raised every cycle outside the grant.
    order_q.delete();
    for (int i = 0; i < 9; i++) begin
      if (k != 1) begin
        if_req = 1'b1; ld_req = 1'b1;
        if_addr = 32'($urandom_range(0, 32'hFF));
        ld_addr = 32'($urandom_range(0, 32'hFF));
      end
      tick();
    end
    if_req = 0; ld_req = 0;
    repeat (3) tick();
    chk("t4_grants", 64'(order_q.size()), 64'd3);
    if (order_q.size() >= 3) begin
      chk("t4_first", 64'(order_q[0]), 64'd1);
`ifdef ROM_ARB_RR_EN
      chk("t4_second", 64'(order_q[1]), 64'd0);
`else
      chk("t4_second", 64'(order_q[1]), 64'd1);
`endif
      chk("t4_third", 64'(order_q[2]), 64'd1);
    end

    // WAIT_CYCLES=3 timing on u3, with a load arriving during the fetch.
    if_addr3 = 32'h20; if_req3 = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      tick();
      chk("t5_if_gnt", 64'(if_gnt3), 64'(c == 1));
      chk("t5_ld_gnt", 64'(ld_gnt3), 64'(c == 6));
      chk("t5_cs", 64'(rom_cs3), 64'(c <= 3 || (c >= 6 && c <= 8)));
      chk("t5_oe", 64'(rom_oe3), 64'(c <= 3 || (c >= 6 && c <= 8)));
      chk("t5_busy", 64'(busy3), 64'(c <= 4 || (c >= 6 && c <= 9)));
      chk("t5_if_valid", 64'(if_valid3), 64'(c == 4));
      chk("t5_ld_valid", 64'(ld_valid3), 64'(c == 9));
      if (c <= 3) chk("t5_addr", 64'(rom_address3), 64'h20);
      if (c == 4) chk("t5_if_data", if_data3, rom_word(32'h20));
      if (c == 9) chk("t5_ld_data", ld_data3, rom_word(32'h44));
      if (c == 1) if_req3 = 1'b0;
      if (c == 2) begin ld_addr3 = 32'h44; ld_req3 = 1'b1; end
      if (c == 6) ld_req3 = 1'b0;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
